// File: rtl/acq_vp_pkg.sv
// acq_vp_pkg: shared types and constants for the acquisition memory viewport
package acq_vp_pkg;
  localparam int DW = 16;
  localparam int FIFO_DEPTH_DEF = 4;
  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DATA, WR_ISSUE} vp_state_t;
endpackage

// File: rtl/acq_vp_fifo.sv
// acq_vp_fifo: register-based synchronous sample FIFO with clear
module acq_vp_fifo
  import acq_vp_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW:0] wr_q, wr_d, rd_q, rd_d;
  logic wen;
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign dout  = mem_q[rd_q[PW-1:0]];
  always_comb begin
    wen = push & (~full | pop);
    mem_d = mem_q;
    if (wen) mem_d[wr_q[PW-1:0]] = din;
    wr_d = clr ? '0 : wr_q + {{PW{1'b0}}, wen};
    rd_d = clr ? '0 : rd_q + {{PW{1'b0}}, pop};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
    mem_q <= mem_d;
  end
endmodule

// File: rtl/acq_vp_mem.sv
// acq_vp_mem: VME viewport responder over a circular acquisition RAM
module acq_vp_mem
  import acq_vp_pkg::*;
#(
  parameter int AW = 16,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [AW:1]   VMEAddr,
  input  logic [DW-1:0] VMEWrData,
  input  logic          VMERdMem,
  input  logic          VMEWrMem,
  output logic [DW-1:0] VMERdData,
  output logic          VMERdDone,
  output logic          VMEWrDone,
  input  logic          acq_enable_i,
  input  logic          acq_valid_i,
  input  logic [DW-1:0] acq_data_i,
  input  logic          acq_clear_i,
  output logic [AW-1:0] acq_wr_ptr_o,
  output logic          acq_wrapped_o,
  output logic          acq_overflow_o
);
  vp_state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, ptr_q, ptr_d, ram_waddr;
  logic [DW-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d, ram_wdata, fifo_dout;
  logic [DW-1:0] ram_q [2**AW];
  logic wrapped_q, wrapped_d, overflow_q, overflow_d;
  logic idle, strobe, vme_own, push, pop, full, empty, ram_we;
  acq_vp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(Clk), .rst(Rst), .clr(acq_clear_i), .push(push), .pop(pop),
    .din(acq_data_i), .dout(fifo_dout), .full(full), .empty(empty)
  );
  always_comb begin
    idle = state_q == IDLE;
    strobe = idle & (VMEWrMem | VMERdMem);
    vme_own = state_q == RD_ISSUE || state_q == WR_ISSUE;
    push = acq_valid_i & acq_enable_i & ~acq_clear_i;
    pop = ~empty & ~vme_own & ~acq_clear_i & ~Rst;
    ram_we = ~Rst & (state_q == WR_ISSUE || pop);
    ram_waddr = state_q == WR_ISSUE ? addr_q : ptr_q;
    ram_wdata = state_q == WR_ISSUE ? wdata_q : fifo_dout;
    rd_data_d = state_q == RD_ISSUE ? ram_q[addr_q] : rd_data_q;
    addr_d = strobe ? VMEAddr : addr_q;
    wdata_d = strobe ? VMEWrData : wdata_q;
    state_d = idle ? (VMEWrMem ? WR_ISSUE : VMERdMem ? RD_ISSUE : IDLE)
            : state_q == RD_ISSUE ? RD_DATA : IDLE;
    ptr_d = acq_clear_i ? '0 : ptr_q + {{(AW-1){1'b0}}, pop};
    wrapped_d = ~acq_clear_i & (wrapped_q | (pop & (&ptr_q)));
    overflow_d = ~acq_clear_i & (overflow_q | (push & full & ~pop));
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rd_data_q <= '0;
      ptr_q <= '0;
      wrapped_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rd_data_q <= rd_data_d;
      ptr_q <= ptr_d;
      wrapped_q <= wrapped_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge Clk) begin
    if (ram_we) ram_q[ram_waddr] <= ram_wdata;
  end
  assign VMERdData = rd_data_q;
  assign VMERdDone = (state_q == RD_DATA) & ~Rst;
  assign VMEWrDone = (state_q == WR_ISSUE) & ~Rst;
  assign acq_wr_ptr_o = ptr_q;
  assign acq_wrapped_o = wrapped_q;
  assign acq_overflow_o = overflow_q;
endmodule

// File: tb/tb_acq_vp_mem.sv
// tb_acq_vp_mem: scoreboard bench for acq_vp_mem (AW=16/FIFO 4 and AW=4/FIFO 2)
module tb_acq_vp_mem;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, en;
  logic [15:0] addr, wdata, adata;
  logic b_rd, b_wr, b_v, b_clr, s_rd, s_wr, s_v, s_clr;
  logic [15:0] b_rdata, s_rdata, b_ptr;
  logic [3:0] s_ptr;
  logic b_rdn, b_wdn, s_rdn, s_wdn, b_wrap, b_ovf, s_wrap, s_ovf;
  int n_cmp = 0, n_err = 0;
  typedef struct {bit wr; logic [15:0] d;} exp_t;
  exp_t qb[$], qs[$];
  logic [15:0] ov_exp [5] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0105};

  acq_vp_mem #(.AW(16), .FIFO_DEPTH(4)) u_big (
    .Clk(clk), .Rst(rst), .VMEAddr(addr), .VMEWrData(wdata), .VMERdMem(b_rd), .VMEWrMem(b_wr),
    .VMERdData(b_rdata), .VMERdDone(b_rdn), .VMEWrDone(b_wdn), .acq_enable_i(en), .acq_valid_i(b_v),
    .acq_data_i(adata), .acq_clear_i(b_clr), .acq_wr_ptr_o(b_ptr), .acq_wrapped_o(b_wrap),
    .acq_overflow_o(b_ovf));
  acq_vp_mem #(.AW(4), .FIFO_DEPTH(2)) u_small (
    .Clk(clk), .Rst(rst), .VMEAddr(addr[3:0]), .VMEWrData(wdata), .VMERdMem(s_rd), .VMEWrMem(s_wr),
    .VMERdData(s_rdata), .VMERdDone(s_rdn), .VMEWrDone(s_wdn), .acq_enable_i(en), .acq_valid_i(s_v),
    .acq_data_i(adata), .acq_clear_i(s_clr), .acq_wr_ptr_o(s_ptr), .acq_wrapped_o(s_wrap),
    .acq_overflow_o(s_ovf));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic vme(input bit s, input bit rd, input bit wr, input logic [15:0] a,
                     input logic [15:0] d, input logic [15:0] ex);
    exp_t e;
    addr = a;
    wdata = d;
    if (s) begin s_rd = rd; s_wr = wr; end else begin b_rd = rd; b_wr = wr; end
    e.wr = wr;
    e.d = ex;
    if (s) qs.push_back(e); else qb.push_back(e);
    tick;
    b_rd = 0; b_wr = 0; s_rd = 0; s_wr = 0;
    @(negedge clk);
    check("wr_done_t1", s ? s_wdn : b_wdn, 32'(wr));
    check("rd_done_t1", s ? s_rdn : b_rdn, 0);
    if (rd && !wr) begin
      @(negedge clk);
      check("rd_done_t2", s ? s_rdn : b_rdn, 1);
    end
    tick;
  endtask

  task automatic feed(input bit s, input logic [15:0] v);
    adata = v;
    if (s) s_v = 1; else b_v = 1;
    tick;
    s_v = 0;
    b_v = 0;
  endtask

  always @(negedge clk) begin
    if (b_rdn || b_wdn) begin
      if (qb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL big_unexpected_done: rd=%0b wr=%0b with none expected", b_rdn, b_wdn);
      end else begin
        exp_t e;
        e = qb.pop_front();
        check("big_done_kind", {30'd0, b_wdn, b_rdn}, e.wr ? 2 : 1);
        if (!e.wr) check("big_rd_data", b_rdata, e.d);
      end
    end
  end

  always @(negedge clk) begin
    if (s_rdn || s_wdn) begin
      if (qs.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL small_unexpected_done: rd=%0b wr=%0b with none expected", s_rdn, s_wdn);
      end else begin
        exp_t e;
        e = qs.pop_front();
        check("small_done_kind", {30'd0, s_wdn, s_rdn}, e.wr ? 2 : 1);
        if (!e.wr) check("small_rd_data", s_rdata, e.d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; en = 0; addr = 0; wdata = 0; adata = 0;
    b_rd = 0; b_wr = 0; b_v = 0; b_clr = 0; s_rd = 0; s_wr = 0; s_v = 0; s_clr = 0;
    repeat (3) tick;
    check("rst_rdata", b_rdata, 0);
    check("rst_rd_done", b_rdn, 0);
    check("rst_wr_done", b_wdn, 0);
    check("rst_ptr", b_ptr, 0);
    check("rst_wrapped", b_wrap, 0);
    check("rst_overflow", b_ovf, 0);
    rst = 0;
    tick;
    vme(0, 0, 1, 16'h0010, 16'hA5A5, 0);
    vme(0, 1, 0, 16'h0010, 0, 16'hA5A5);
    vme(0, 1, 1, 16'h0003, 16'h1234, 0);
    vme(0, 1, 0, 16'h0003, 0, 16'h1234);
    en = 1;
    for (int i = 1; i <= 5; i++) feed(0, 16'(i));
    repeat (4) tick;
    check("fill_ptr", b_ptr, 5);
    check("fill_wrapped", b_wrap, 0);
    check("fill_overflow", b_ovf, 0);
    for (int i = 0; i < 5; i++) vme(0, 1, 0, 16'(i), 0, 16'(i + 1));
    for (int i = 1; i <= 17; i++) feed(1, 16'(i));
    repeat (4) tick;
    check("wrap_ptr", s_ptr, 1);
    check("wrap_flag", s_wrap, 1);
    check("wrap_overflow", s_ovf, 0);
    vme(1, 1, 0, 16'h0000, 0, 16'd17);
    vme(1, 1, 0, 16'h0001, 0, 16'd2);
    s_clr = 1;
    tick;
    s_clr = 0;
    check("clr_ptr", s_ptr, 0);
    check("clr_wrapped", s_wrap, 0);
    check("clr_overflow", s_ovf, 0);
    fork
      begin
        for (int c = 0; c < 6; c++) begin
          if (c == 4) check("ovf_before_drop", s_ovf, 0);
          adata = 16'(16'h0100 + c);
          s_v = 1;
          tick;
        end
        s_v = 0;
      end
      begin
        vme(1, 1, 0, 16'h0008, 0, 16'd9);
        vme(1, 1, 0, 16'h0009, 0, 16'd10);
      end
    join
    repeat (3) tick;
    check("ovf_ptr", s_ptr, 5);
    check("ovf_flag", s_ovf, 1);
    check("ovf_wrapped", s_wrap, 0);
    for (int i = 0; i < 5; i++) vme(1, 1, 0, 16'(i), 0, ov_exp[i]);
    vme(0, 0, 1, 16'h0020, 16'hBEEF, 0);
    addr = 16'h0020;
    b_rd = 1;
    tick;
    b_rd = 0;
    tick;
    rst = 1;
    @(negedge clk);
    check("rst_in_rd_data_done", b_rdn, 0);
    tick;
    rst = 0;
    check("post_rst_rdata", b_rdata, 0);
    check("post_rst_rd_done", b_rdn, 0);
    check("post_rst_wr_done", b_wdn, 0);
    check("post_rst_ptr", b_ptr, 0);
    check("post_rst_small_ovf", s_ovf, 0);
    check("post_rst_small_ptr", s_ptr, 0);
    tick;
    feed(0, 16'h0077);
    adata = 16'h0078;
    b_v = 1;
    b_clr = 1;
    tick;
    b_v = 0;
    b_clr = 0;
    repeat (3) tick;
    check("clr_push_ptr", b_ptr, 0);
    check("clr_push_overflow", b_ovf, 0);
    vme(0, 1, 0, 16'h0000, 0, 16'd1);
    repeat (2) tick;
    check("big_queue_empty", qb.size(), 0);
    check("small_queue_empty", qs.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
